// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_if
//  Description : Instruction-memory request/acknowledge bus between the fetch
//                unit (master) and instruction memory (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch/decode-front stage. Holds the PC, fetches 8-bit
//                instructions over a req/ack bus, latches them into IR and
//                splits them into op/rs/rt/rd/imm. Advances when not stalled,
//                accepts branch redirects (redirect beats stall and ack).
//  Option      : IFU_STALL_CNT_EN adds a saturating 16-bit stall_cnt output
//                counting cycles with instr_valid && stall.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 8,
    parameter int RESET_PC = 0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    instr_fetch_unit_if.master      imem,
    input  wire logic               stall,
    input  wire logic               br_taken,
    input  wire logic [PC_W-1:0]    br_target,
    output logic                    instr_valid,
    output logic [INSTR_W-1:0]      instr,
    output logic [1:0]              op,
    output logic [1:0]              rs,
    output logic [1:0]              rt,
    output logic [1:0]              rd,
    output logic [7:0]              imm,
    output logic [PC_W-1:0]         pc_out
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] C_RESET_PC = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] C_PC_ONE   = PC_W'(1);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0]    pc_out_q, pc_out_d;

    // State, PC, IR and IR-address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= C_RESET_PC;
            ir_q     <= '0;
            pc_out_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            pc_out_q <= pc_out_d;
        end
    end

    // Next-state logic: redirect first, then ack (REQ) or advance (HOLD)
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        pc_out_d = pc_out_q;
        case (state_q)
            ST_IDLE: begin
                // Redirects and stray acks are ignored for this one cycle.
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (br_taken) begin
                    // Data returning with the redirect belongs to the
                    // abandoned path, so IR keeps its old value.
                    pc_d = br_target;
                end else if (imem.imem_ack) begin
                    ir_d     = imem.imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (br_taken) begin
                    pc_d    = br_target;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    pc_d    = pc_q + C_PC_ONE;   // wraps modulo 2^PC_W
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus and decode outputs are pure functions of the registered state
    always_comb begin
        imem.imem_req  = (state_q == ST_REQ);
        imem.imem_addr = pc_q;
        instr_valid    = (state_q == ST_HOLD);
        instr          = ir_q;
        op             = ir_q[7:6];
        rs             = ir_q[5:4];
        rt             = ir_q[3:2];
        rd             = ir_q[1:0];
        imm            = {{6{ir_q[1]}}, ir_q[1:0]};
        pc_out         = pc_out_q;
    end

`ifdef IFU_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a valid instruction is held by stall
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (instr_valid && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
